unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency 32-bit block RAM between the pipeline's instruction-fetch port and data-memory port.
- Lets the 5-stage MIPS core run from one unified memory instead of separate instruction and data RAMs.
- Data accesses have priority. A starvation counter guarantees fetch progress.
- Each port uses a req/ack handshake. The core stalls its stage while req is high and ack is low.

Parameters:
- AW, 10, word-address width of the RAM (depth 2^AW words).
- STARVE_LIM, 3, number of consecutive data grants made while fetch waits, after which fetch wins the next arbitration.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high with if_addr stable until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata/if_err valid
- if_rdata  out  32  fetched instruction
- if_err  out  1  with if_ack: misaligned or out-of-range fetch
- dm_req  in  1  data request; held high with dm_we/dm_be/dm_addr/dm_wdata stable until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_be  in  4  byte enables for writes (bit i = byte lane i)
- dm_addr  in  32  data byte address
- dm_wdata  in  32  write data
- dm_ack  out  1  one-cycle pulse: data access complete
- dm_rdata  out  32  read data, valid with dm_ack on reads; 0 on writes and errors
- dm_err  out  1  with dm_ack: misaligned or out-of-range access
- ram_ena  out  1  RAM enable
- ram_wea  out  4  RAM byte write enables
- ram_addr  out  AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after the issuing edge

Behaviour:
- FSM has three states: IDLE, D_RESP, I_RESP. The state register, if_wait_cnt and the error latch are the only state.
- Reset (rst=1 at an edge, including mid-access):
  - state←IDLE, if_wait_cnt←0.
  - No ack is issued for an interrupted access; the requester must retry.
  - The reset cycle forces ram_ena=0 and ram_wea=0.
- Address check for port X:
  - ok = (addr[1:0]==0) && (addr[31:AW+2]==0).
  - Word address = addr[AW+1:2].
- IDLE arbitration (combinational, same cycle):
  - Fetch wins if if_req && (!dm_req || if_wait_cnt==STARVE_LIM). Otherwise data wins if dm_req.
  - Winner with ok=1: ram_ena=1, ram_addr=word address.
    - Data write: ram_wea=dm_be, ram_wdata=dm_wdata.
    - Reads: ram_wea=0.
  - Winner with ok=0: ram_ena=0; the error is latched.
  - Next state: D_RESP or I_RESP. With no request, stay in IDLE.
- Idle drive values: when no access is issued, ram_ena=0, ram_wea=0, ram_addr=0, ram_wdata=0.
- D_RESP (one cycle), then always IDLE:
  - dm_ack=1, dm_err=latched error.
  - dm_rdata = ram_rdata if read && !err, else 0.
  - RAM is not driven.
- I_RESP (one cycle), then always IDLE:
  - if_ack=1, if_err=latched error.
  - if_rdata = err ? 0 : ram_rdata.
- Outside the RESP states: acks=0, err=0, rdata=0. These are also the reset values.
- Latency and throughput:
  - An uncontended request is granted in cycle n and acked in cycle n+1.
  - One access per 2 cycles. No back-to-back grants; the RESP cycle never arbitrates.
- if_wait_cnt:
  - Increments (saturating at STARVE_LIM) on each IDLE data grant while if_req=1.
  - Clears on any fetch grant.
  - Holds otherwise.
- Requester dropping req before ack is a protocol violation; behaviour is unspecified except that the FSM returns to IDLE.
- Simultaneous if_req and dm_req with count<STARVE_LIM: data wins, and if_ack comes no earlier than 2 cycles after dm_ack.

Test Plan:
- Uncontended data read:
  - Preload word 5=0xDEADBEEF.
  - dm_req=1, dm_we=0, dm_addr=0x14 in cycle 0.
  - Expect ram_ena=1, ram_addr=5 in cycle 0; dm_ack=1, dm_rdata=0xDEADBEEF in cycle 1; IDLE in cycle 2.
- Byte write:
  - Word 2=0x11223344; write dm_addr=0x8, dm_be=4'b0011, dm_wdata=0xAABBCCDD.
  - Expect ram_wea=4'b0011 and dm_ack the next cycle.
  - Reading word 2 returns 0x1122CCDD.
- Contention with starvation limit:
  - Hold dm_req and if_req high; re-raise dm_req immediately after each ack.
  - Expect grant order D,D,D,I,D,D,D,I; if_ack every 8th cycle; if_wait_cnt reaches 3 and then clears.
- Error paths:
  - dm_addr=0x6 gives dm_ack with dm_err=1, dm_rdata=0, ram_ena never asserted.
  - if_addr=0x1000 (AW=10) gives if_ack with if_err=1, if_rdata=0.
- Reset mid-access:
  - Assert rst in the cycle after a fetch grant.
  - Expect no if_ack, ram_ena=0, state IDLE, if_wait_cnt=0.
  - A re-issued fetch afterwards completes normally in 2 cycles.
- Idle hold:
  - No requests for 10 cycles.
  - Expect ram_ena=0, ram_wea=0, all acks=0, no RAM contents changed.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, 1-cycle-latency block RAM between instruction fetch and data memory.
// Data wins arbitration; a starvation counter forces a fetch grant after STARVE_LIM data grants.
module unified_mem_arbiter #(
    parameter int AW         = 10,
    parameter int STARVE_LIM = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_ack,
    output logic [31:0]   dm_rdata,
    output logic          dm_err,
    output logic          ram_ena,
    output logic [3:0]    ram_wea,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);
    localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE = 2'd0, D_RESP = 2'd1, I_RESP = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] if_wait_cnt;
    logic          err_q, err_nxt;
    logic          if_grant, dm_grant;
    logic          if_ok, dm_ok;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    assign if_ok = addr_ok(if_addr);
    assign dm_ok = addr_ok(dm_addr);

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        if_grant  = 1'b0;
        dm_grant  = 1'b0;
        ram_ena   = 1'b0;
        ram_wea   = 4'b0;
        ram_addr  = '0;
        ram_wdata = 32'b0;
        if_ack    = 1'b0;
        if_err    = 1'b0;
        if_rdata  = 32'b0;
        dm_ack    = 1'b0;
        dm_err    = 1'b0;
        dm_rdata  = 32'b0;
        case (state)
            IDLE: begin
                if (if_req && (!dm_req || if_wait_cnt == LIM)) begin
                    if_grant  = 1'b1;
                    state_nxt = I_RESP;
                    err_nxt   = !if_ok;
                    if (if_ok) begin
                        ram_ena  = 1'b1;
                        ram_addr = if_addr[AW+1:2];
                    end
                end else if (dm_req) begin
                    dm_grant  = 1'b1;
                    state_nxt = D_RESP;
                    err_nxt   = !dm_ok;
                    if (dm_ok) begin
                        ram_ena  = 1'b1;
                        ram_addr = dm_addr[AW+1:2];
                        if (dm_we) begin
                            ram_wea   = dm_be;
                            ram_wdata = dm_wdata;
                        end
                    end
                end
            end
            // Response cycles never arbitrate, so throughput is one access per two cycles.
            D_RESP: begin
                state_nxt = IDLE;
                if (!rst) begin
                    dm_ack   = 1'b1;
                    dm_err   = err_q;
                    dm_rdata = (!dm_we && !err_q) ? ram_rdata : 32'b0;
                end
            end
            I_RESP: begin
                state_nxt = IDLE;
                if (!rst) begin
                    if_ack   = 1'b1;
                    if_err   = err_q;
                    if_rdata = err_q ? 32'b0 : ram_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // An access caught by reset must not touch the RAM.
        if (rst) begin
            ram_ena = 1'b0;
            ram_wea = 4'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            if_wait_cnt <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (if_grant)
                if_wait_cnt <= '0;
            else if (dm_grant && if_req && if_wait_cnt != LIM)
                if_wait_cnt <= if_wait_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural 1-cycle-latency byte-writable RAM.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack, dm_err;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        ram_ena;
    logic [3:0]  ram_wea;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [0:1023];
    int tests = 0;
    int fails = 0;

    unified_mem_arbiter #(.AW(10), .STARVE_LIM(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Read-first RAM: returns the pre-write word one cycle after the enabled edge.
    always @(posedge clk) begin
        if (ram_ena) begin
            for (int b = 0; b < 4; b++)
                if (ram_wea[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_if;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ena;
        logic [3:0]  exp_wea;
        logic [9:0]  exp_raddr;
        logic [31:0] exp_wd;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [12];

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    endtask

    initial begin
        mem[5]    <= 32'hDEADBEEF;
        mem[2]    <= 32'h11223344;
        mem[1023] <= 32'h5A5A0001;
        ram_rdata = 32'h0;
        idle_inputs();
        rst = 1'b1;

        vt[0]  = '{0, 0, 4'hF, 32'h14,   32'h0,        1, 4'h0, 10'd5,   32'h0,        0, 32'hDEADBEEF};
        vt[1]  = '{0, 1, 4'h3, 32'h8,    32'hAABBCCDD, 1, 4'h3, 10'd2,   32'hAABBCCDD, 0, 32'h0};
        vt[2]  = '{0, 0, 4'h0, 32'h8,    32'h0,        1, 4'h0, 10'd2,   32'h0,        0, 32'h1122CCDD};
        vt[3]  = '{0, 0, 4'h0, 32'h6,    32'h0,        0, 4'h0, 10'd0,   32'h0,        1, 32'h0};
        vt[4]  = '{1, 0, 4'h0, 32'h14,   32'h0,        1, 4'h0, 10'd5,   32'h0,        0, 32'hDEADBEEF};
        vt[5]  = '{1, 0, 4'h0, 32'h1000, 32'h0,        0, 4'h0, 10'd0,   32'h0,        1, 32'h0};
        vt[6]  = '{0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 0, 4'h0, 10'd0,   32'h0,        1, 32'h0};
        vt[7]  = '{0, 0, 4'h0, 32'hFFC,  32'h0,        1, 4'h0, 10'd1023, 32'h0,       0, 32'h5A5A0001};
        vt[8]  = '{1, 0, 4'h0, 32'h2,    32'h0,        0, 4'h0, 10'd0,   32'h0,        1, 32'h0};
        vt[9]  = '{0, 1, 4'hF, 32'h20,   32'h12345678, 1, 4'hF, 10'd8,   32'h12345678, 0, 32'h0};
        vt[10] = '{1, 0, 4'h0, 32'h20,   32'h0,        1, 4'h0, 10'd8,   32'h0,        0, 32'h12345678};
        vt[11] = '{1, 0, 4'h0, 32'h8,    32'h0,        1, 4'h0, 10'd2,   32'h0,        0, 32'h1122CCDD};

        // Reset state
        @(negedge clk);
        chk("rst_ram_ena", 32'(ram_ena), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(dut.state), 32'h0);
        chk("rst_wait_cnt", 32'(dut.if_wait_cnt), 32'h0);
        chk("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
        @(posedge clk); #1;

        // Table-driven single transactions: grant cycle, ack cycle, back to IDLE
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            if (vt[i].is_if) begin
                if_req = 1'b1; if_addr = vt[i].addr;
            end else begin
                dm_req = 1'b1; dm_we = vt[i].we; dm_be = vt[i].be;
                dm_addr = vt[i].addr; dm_wdata = vt[i].wdata;
            end
            @(negedge clk);
            chk($sformatf("v%0d_ram_ena", i), 32'(ram_ena), 32'(vt[i].exp_ena));
            chk($sformatf("v%0d_ram_wea", i), 32'(ram_wea), 32'(vt[i].exp_wea));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vt[i].exp_raddr));
            if (vt[i].exp_wea != 4'h0)
                chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vt[i].exp_wd);
            chk($sformatf("v%0d_no_early_ack", i), {30'h0, if_ack, dm_ack}, 32'h0);
            @(posedge clk); #1;
            if (vt[i].is_if) begin
                chk($sformatf("v%0d_if_ack", i), {30'h0, if_ack, dm_ack}, 32'h2);
                chk($sformatf("v%0d_if_err", i), 32'(if_err), 32'(vt[i].exp_err));
                chk($sformatf("v%0d_if_rdata", i), if_rdata, vt[i].exp_rdata);
            end else begin
                chk($sformatf("v%0d_dm_ack", i), {30'h0, if_ack, dm_ack}, 32'h1);
                chk($sformatf("v%0d_dm_err", i), 32'(dm_err), 32'(vt[i].exp_err));
                chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vt[i].exp_rdata);
            end
            chk($sformatf("v%0d_resp_no_ram", i), 32'(ram_ena), 32'h0);
            @(posedge clk); #1;
            idle_inputs();
            chk($sformatf("v%0d_back_idle", i), 32'(dut.state), 32'h0);
        end

        // Contention: both held high; grants must go D,D,D,I repeating
        chk("cont_cnt_start", 32'(dut.if_wait_cnt), 32'h0);
        dm_req = 1'b1; dm_addr = 32'h14; if_req = 1'b1; if_addr = 32'h8;
        for (int k = 0; k < 16; k++) begin
            automatic int  g = k / 2;
            automatic bit  fetch = (g % 4) == 3;
            @(negedge clk);
            if ((k % 2) == 0) begin
                chk($sformatf("cont%0d_grant_addr", k), 32'(ram_addr), fetch ? 32'd2 : 32'd5);
                chk($sformatf("cont%0d_wait_cnt", k), 32'(dut.if_wait_cnt), 32'(g % 4));
            end else begin
                chk($sformatf("cont%0d_acks", k), {30'h0, if_ack, dm_ack}, fetch ? 32'h2 : 32'h1);
            end
            @(posedge clk); #1;
        end
        chk("cont_cnt_cleared", 32'(dut.if_wait_cnt), 32'h0);
        idle_inputs();
        @(posedge clk); #1;

        // Reset during a data response with a fetch waiting: no ack, counter cleared
        dm_req = 1'b1; dm_addr = 32'h14; if_req = 1'b1; if_addr = 32'h8;
        @(posedge clk); #1;
        chk("rstd_cnt_before", 32'(dut.if_wait_cnt), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstd_no_ack", {30'h0, if_ack, dm_ack}, 32'h0);
        chk("rstd_ram_ena", 32'(ram_ena), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        idle_inputs();
        chk("rstd_state", 32'(dut.state), 32'h0);
        chk("rstd_cnt", 32'(dut.if_wait_cnt), 32'h0);

        // Reset the cycle after a fetch grant, then retry the fetch
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("rsti_grant", 32'(ram_ena), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rsti_no_ack", 32'(if_ack), 32'h0);
        chk("rsti_ram_ena", 32'(ram_ena), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rsti_state", 32'(dut.state), 32'h0);
        chk("rsti_cnt", 32'(dut.if_wait_cnt), 32'h0);
        @(negedge clk);
        chk("retry_grant_addr", {21'h0, ram_ena, ram_addr}, {21'h0, 1'b1, 10'd5});
        @(posedge clk); #1;
        chk("retry_if_ack", 32'(if_ack), 32'h1);
        chk("retry_if_rdata", if_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        idle_inputs();

        // Idle hold: nothing issued, nothing acked, memory untouched
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_quiet", k), {26'h0, ram_wea, ram_ena, if_ack, dm_ack}, 32'h0);
        end
        chk("idle_mem2", mem[2], 32'h1122CCDD);
        chk("idle_mem5", mem[5], 32'hDEADBEEF);
        chk("idle_mem8", mem[8], 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
